// File: rtl/packetmem_nbuf_pkg.sv
// Shared definitions for the N-buffer packet memory: buffer ownership states
// and the index-width helper.
package packetmem_nbuf_pkg;

  typedef enum logic [2:0] {
    BS_FREE,
    BS_SNOOP,
    BS_Q_CPU,
    BS_CPU,
    BS_Q_FWD,
    BS_FWD
  } buf_state_e;

  localparam int DROP_W = 16;

  // Index width that stays at least 1 bit so a single-entry range still has a port.
  function automatic int buf_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/packet_ram.sv
// One packet buffer: a wide write port and two independent wide read ports
// with 1-cycle latency and held output.
module packet_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    i_wr_en,
  input  logic [ADDR_WIDTH-2:0]   i_wr_addr,
  input  logic [2*DATA_WIDTH-1:0] i_wr_data,
  input  logic                    i_rda_en,
  input  logic [ADDR_WIDTH-2:0]   i_rda_addr,
  output logic [2*DATA_WIDTH-1:0] o_rda_data,
  input  logic                    i_rdb_en,
  input  logic [ADDR_WIDTH-2:0]   i_rdb_addr,
  output logic [2*DATA_WIDTH-1:0] o_rdb_data
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 1);

  logic [2*DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [2*DATA_WIDTH-1:0] r_rda_data;
  logic [2*DATA_WIDTH-1:0] r_rdb_data;

  always_ff @(posedge clk) begin
    if (i_wr_en)  r_mem[i_wr_addr] <= i_wr_data;
    if (i_rda_en) r_rda_data <= r_mem[i_rda_addr];
    if (i_rdb_en) r_rdb_data <= r_mem[i_rdb_addr];
  end

  assign o_rda_data = r_rda_data;
  assign o_rdb_data = r_rdb_data;

endmodule

// File: rtl/packetmem_nbuf_buf_idx_fifo.sv
// Ordered queue of buffer indices; depth equals the buffer count, so it can
// never overflow while every buffer is in exactly one place.
module packetmem_nbuf_buf_idx_fifo
  import packetmem_nbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_idx,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_empty
);

  localparam int PW = buf_idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_idx;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/packetmem_nbuf.sv
// N-buffer packet memory shared by snooper, filter CPU and forwarder, with
// per-buffer ownership, ordered hand-off queues and a drop counter.
//
// state    | meaning
// FREE     | unowned, available to the snooper (lowest index first)
// SNOOP    | held by the snooper while a packet is written
// Q_CPU    | complete packet waiting in the CPU queue
// CPU      | held by the filter CPU
// Q_FWD    | accepted packet waiting in the forwarder queue
// FWD      | held by the forwarder
module packetmem_nbuf
  import packetmem_nbuf_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int N_BUFS     = 4,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 3,
  parameter int BUF_IDX_W  = buf_idx_w(N_BUFS)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    snooper_valid,
  output logic [BUF_IDX_W-1:0]    snooper_buf,
  input  logic [ADDR_WIDTH-1:0]   snooper_wr_addr,
  input  logic [2*DATA_WIDTH-1:0] snooper_wr_data,
  input  logic                    snooper_wr_en,
  input  logic [LEN_WIDTH-1:0]    snooper_len,
  input  logic                    snooper_done,
  output logic                    cpu_valid,
  output logic [LEN_WIDTH-1:0]    cpu_len,
  input  logic [ADDR_WIDTH-1:0]   cpu_rd_addr,
  input  logic                    cpu_rd_en,
  output logic [2*DATA_WIDTH-1:0] cpu_rd_data,
  input  logic                    cpu_acc,
  input  logic                    cpu_rej,
  output logic                    fwd_valid,
  output logic [LEN_WIDTH-1:0]    fwd_len,
  input  logic [ADDR_WIDTH-1:0]   fwd_rd_addr,
  input  logic                    fwd_rd_en,
  output logic [2*DATA_WIDTH-1:0] fwd_rd_data,
  input  logic                    fwd_done,
  output logic [DROP_W-1:0]       drop_cnt
);

  buf_state_e           r_state [N_BUFS];
  logic [LEN_WIDTH-1:0] r_len   [N_BUFS];

  logic                 r_snp_valid, r_cpu_valid, r_fwd_valid;
  logic [BUF_IDX_W-1:0] r_snp_buf, r_cpu_buf, r_fwd_buf;
  logic [LEN_WIDTH-1:0] r_cpu_len, r_fwd_len;
  logic [DROP_W-1:0]    r_drop_cnt;
  logic                 r_cpu_rd_ok, r_fwd_rd_ok;
  logic [BUF_IDX_W-1:0] r_cpu_rd_sel, r_fwd_rd_sel;

  logic                 w_free_any;
  logic [BUF_IDX_W-1:0] w_free_idx;
  logic                 w_snp_grant, w_snp_rel;
  logic                 w_cpu_pop, w_cpu_rel, w_fwd_pop, w_fwd_rel;
  logic                 w_qcpu_empty, w_qfwd_empty;
  logic [BUF_IDX_W-1:0] w_qcpu_head, w_qfwd_head;
  logic [2*DATA_WIDTH-1:0] w_cpu_q [N_BUFS];
  logic [2*DATA_WIDTH-1:0] w_fwd_q [N_BUFS];
  logic                 w_unused_addr_lsb;

  // Descending scan so the last hit is the lowest free index.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = N_BUFS - 1; i >= 0; i--) begin
      if (r_state[i] == BS_FREE) begin
        w_free_any = 1'b1;
        w_free_idx = BUF_IDX_W'(i);
      end
    end
  end

  assign w_snp_grant = ~r_snp_valid & w_free_any;
  assign w_snp_rel   = r_snp_valid & snooper_done;
  assign w_cpu_pop   = ~r_cpu_valid & ~w_qcpu_empty;
  assign w_cpu_rel   = r_cpu_valid & (cpu_acc | cpu_rej);
  assign w_fwd_pop   = ~r_fwd_valid & ~w_qfwd_empty;
  assign w_fwd_rel   = r_fwd_valid & fwd_done;

  packetmem_nbuf_buf_idx_fifo #(.DEPTH(N_BUFS), .W(BUF_IDX_W)) u_q_cpu (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_snp_rel),
    .i_push_idx (r_snp_buf),
    .i_pop      (w_cpu_pop),
    .o_head     (w_qcpu_head),
    .o_empty    (w_qcpu_empty)
  );

  packetmem_nbuf_buf_idx_fifo #(.DEPTH(N_BUFS), .W(BUF_IDX_W)) u_q_fwd (
    .clk        (clk),
    .rst        (rst),
    .i_push     (r_cpu_valid & cpu_acc),
    .i_push_idx (r_cpu_buf),
    .i_pop      (w_fwd_pop),
    .o_head     (w_qfwd_head),
    .o_empty    (w_qfwd_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BUFS; i++) begin
        r_state[i] <= BS_FREE;
        r_len[i]   <= '0;
      end
      r_snp_valid  <= 1'b0;
      r_snp_buf    <= '0;
      r_cpu_valid  <= 1'b0;
      r_cpu_buf    <= '0;
      r_cpu_len    <= '0;
      r_fwd_valid  <= 1'b0;
      r_fwd_buf    <= '0;
      r_fwd_len    <= '0;
      r_drop_cnt   <= '0;
      r_cpu_rd_ok  <= 1'b0;
      r_cpu_rd_sel <= '0;
      r_fwd_rd_ok  <= 1'b0;
      r_fwd_rd_sel <= '0;
    end else begin
      if (w_snp_grant) begin
        r_snp_valid         <= 1'b1;
        r_snp_buf           <= w_free_idx;
        r_state[w_free_idx] <= BS_SNOOP;
      end else if (w_snp_rel) begin
        r_snp_valid        <= 1'b0;
        r_state[r_snp_buf] <= BS_Q_CPU;
        r_len[r_snp_buf]   <= snooper_len;
      end

      if (snooper_done && !r_snp_valid && r_drop_cnt != '1)
        r_drop_cnt <= r_drop_cnt + 1'b1;

      if (w_cpu_pop) begin
        r_cpu_valid          <= 1'b1;
        r_cpu_buf            <= w_qcpu_head;
        r_cpu_len            <= r_len[w_qcpu_head];
        r_state[w_qcpu_head] <= BS_CPU;
      end else if (w_cpu_rel) begin
        r_cpu_valid        <= 1'b0;
        r_state[r_cpu_buf] <= cpu_acc ? BS_Q_FWD : BS_FREE;
      end

      if (w_fwd_pop) begin
        r_fwd_valid          <= 1'b1;
        r_fwd_buf            <= w_qfwd_head;
        r_fwd_len            <= r_len[w_qfwd_head];
        r_state[w_qfwd_head] <= BS_FWD;
      end else if (w_fwd_rel) begin
        r_fwd_valid        <= 1'b0;
        r_state[r_fwd_buf] <= BS_FREE;
      end

      // Read source is frozen at the rd_en cycle so a release cannot retarget it.
      if (cpu_rd_en) begin
        r_cpu_rd_ok  <= r_cpu_valid;
        r_cpu_rd_sel <= r_cpu_buf;
      end
      if (fwd_rd_en) begin
        r_fwd_rd_ok  <= r_fwd_valid;
        r_fwd_rd_sel <= r_fwd_buf;
      end
    end
  end

  for (genvar g = 0; g < N_BUFS; g++) begin : g_buf
    logic w_wr_en, w_cpu_rd_en, w_fwd_rd_en;
    assign w_wr_en     = snooper_wr_en & r_snp_valid & (r_snp_buf == BUF_IDX_W'(g));
    assign w_cpu_rd_en = cpu_rd_en & r_cpu_valid & (r_cpu_buf == BUF_IDX_W'(g));
    assign w_fwd_rd_en = fwd_rd_en & r_fwd_valid & (r_fwd_buf == BUF_IDX_W'(g));

    packet_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
      .clk        (clk),
      .i_wr_en    (w_wr_en),
      .i_wr_addr  (snooper_wr_addr[ADDR_WIDTH-1:1]),
      .i_wr_data  (snooper_wr_data),
      .i_rda_en   (w_cpu_rd_en),
      .i_rda_addr (cpu_rd_addr[ADDR_WIDTH-1:1]),
      .o_rda_data (w_cpu_q[g]),
      .i_rdb_en   (w_fwd_rd_en),
      .i_rdb_addr (fwd_rd_addr[ADDR_WIDTH-1:1]),
      .o_rdb_data (w_fwd_q[g])
    );
  end

  // Narrow-address LSB selects a half word, which the external adapter handles.
  assign w_unused_addr_lsb = ^{snooper_wr_addr[0], cpu_rd_addr[0], fwd_rd_addr[0]};

  assign snooper_valid = r_snp_valid;
  assign snooper_buf   = r_snp_buf;
  assign cpu_valid     = r_cpu_valid;
  assign cpu_len       = r_cpu_len;
  assign fwd_valid     = r_fwd_valid;
  assign fwd_len       = r_fwd_len;
  assign drop_cnt      = r_drop_cnt;
  assign cpu_rd_data   = r_cpu_rd_ok ? w_cpu_q[r_cpu_rd_sel] : '0;
  assign fwd_rd_data   = r_fwd_rd_ok ? w_fwd_q[r_fwd_rd_sel] : '0;

endmodule

// File: tb/tb_packetmem_nbuf.sv
// Directed bench for packetmem_nbuf: a queue-based ownership model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_packetmem_nbuf;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int LW = AW + 3;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          snooper_valid;
  logic [BW-1:0] snooper_buf;
  logic [AW-1:0] snooper_wr_addr = '0;
  logic [2*DW-1:0] snooper_wr_data = '0;
  logic          snooper_wr_en = 1'b0;
  logic [LW-1:0] snooper_len = '0;
  logic          snooper_done = 1'b0;
  logic          cpu_valid;
  logic [LW-1:0] cpu_len;
  logic [AW-1:0] cpu_rd_addr = '0;
  logic          cpu_rd_en = 1'b0;
  logic [2*DW-1:0] cpu_rd_data;
  logic          cpu_acc = 1'b0;
  logic          cpu_rej = 1'b0;
  logic          fwd_valid;
  logic [LW-1:0] fwd_len;
  logic [AW-1:0] fwd_rd_addr = '0;
  logic          fwd_rd_en = 1'b0;
  logic [2*DW-1:0] fwd_rd_data;
  logic          fwd_done = 1'b0;
  logic [15:0]   drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  packetmem_nbuf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_BUFS(NB)) dut (
    .clk(clk), .rst(rst),
    .snooper_valid(snooper_valid), .snooper_buf(snooper_buf),
    .snooper_wr_addr(snooper_wr_addr), .snooper_wr_data(snooper_wr_data),
    .snooper_wr_en(snooper_wr_en), .snooper_len(snooper_len), .snooper_done(snooper_done),
    .cpu_valid(cpu_valid), .cpu_len(cpu_len), .cpu_rd_addr(cpu_rd_addr),
    .cpu_rd_en(cpu_rd_en), .cpu_rd_data(cpu_rd_data), .cpu_acc(cpu_acc), .cpu_rej(cpu_rej),
    .fwd_valid(fwd_valid), .fwd_len(fwd_len), .fwd_rd_addr(fwd_rd_addr),
    .fwd_rd_en(fwd_rd_en), .fwd_rd_data(fwd_rd_data), .fwd_done(fwd_done),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_free [NB] = '{default: 1'b1};
  int          m_len  [NB] = '{default: 0};
  int          q_cpu[$];
  int          q_fwd[$];
  bit          m_snp_v = 0, m_cpu_v = 0, m_fwd_v = 0;
  int          m_snp_buf = 0, m_cpu_buf = 0, m_fwd_buf = 0;
  int          m_cpu_len = 0, m_fwd_len = 0;
  int          m_drop = 0;
  logic [63:0] mem_m [int];
  bit          m_cpu_known = 1, m_fwd_known = 1;
  logic [63:0] m_cpu_rd = '0, m_fwd_rd = '0;

  function automatic int mkey(input int b, input logic [AW-1:0] a);
    return b * (1 << AW) + int'(a >> 1);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < NB; i++) m_free[i] = 1'b1;
        q_cpu.delete(); q_fwd.delete();
        m_snp_v = 0; m_cpu_v = 0; m_fwd_v = 0;
        m_snp_buf = 0; m_cpu_buf = 0; m_fwd_buf = 0;
        m_cpu_len = 0; m_fwd_len = 0; m_drop = 0;
        m_cpu_known = 1; m_fwd_known = 1; m_cpu_rd = '0; m_fwd_rd = '0;
      end else begin
        int  g;
        bit  cpu_pop, fwd_pop;
        // reads capture the data present now
        if (cpu_rd_en) begin
          if (!m_cpu_v) begin m_cpu_known = 1; m_cpu_rd = '0; end
          else if (mem_m.exists(mkey(m_cpu_buf, cpu_rd_addr))) begin
            m_cpu_known = 1; m_cpu_rd = mem_m[mkey(m_cpu_buf, cpu_rd_addr)];
          end else m_cpu_known = 0;
        end
        if (fwd_rd_en) begin
          if (!m_fwd_v) begin m_fwd_known = 1; m_fwd_rd = '0; end
          else if (mem_m.exists(mkey(m_fwd_buf, fwd_rd_addr))) begin
            m_fwd_known = 1; m_fwd_rd = mem_m[mkey(m_fwd_buf, fwd_rd_addr)];
          end else m_fwd_known = 0;
        end
        if (snooper_wr_en && m_snp_v) mem_m[mkey(m_snp_buf, snooper_wr_addr)] = snooper_wr_data;
        // decisions use the pre-edge picture
        g = -1;
        for (int i = NB - 1; i >= 0; i--) if (m_free[i]) g = i;
        cpu_pop = !m_cpu_v && q_cpu.size() > 0;
        fwd_pop = !m_fwd_v && q_fwd.size() > 0;
        if (fwd_pop) begin
          m_fwd_buf = q_fwd.pop_front(); m_fwd_v = 1; m_fwd_len = m_len[m_fwd_buf];
        end else if (m_fwd_v && fwd_done) begin
          m_free[m_fwd_buf] = 1; m_fwd_v = 0;
        end
        if (cpu_pop) begin
          m_cpu_buf = q_cpu.pop_front(); m_cpu_v = 1; m_cpu_len = m_len[m_cpu_buf];
        end else if (m_cpu_v && (cpu_acc || cpu_rej)) begin
          if (cpu_acc) q_fwd.push_back(m_cpu_buf);
          else m_free[m_cpu_buf] = 1;
          m_cpu_v = 0;
        end
        if (!m_snp_v) begin
          if (snooper_done && m_drop < 16'hFFFF) m_drop++;
          if (g >= 0) begin m_snp_v = 1; m_snp_buf = g; m_free[g] = 0; end
        end else if (snooper_done) begin
          m_len[m_snp_buf] = int'(snooper_len);
          q_cpu.push_back(m_snp_buf);
          m_snp_v = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("m_snooper_valid", {63'd0, snooper_valid}, {63'd0, m_snp_v});
      if (m_snp_v) chk("m_snooper_buf", 64'(snooper_buf), 64'(m_snp_buf));
      chk("m_cpu_valid", {63'd0, cpu_valid}, {63'd0, m_cpu_v});
      if (m_cpu_v) chk("m_cpu_len", 64'(cpu_len), 64'(m_cpu_len));
      chk("m_fwd_valid", {63'd0, fwd_valid}, {63'd0, m_fwd_v});
      if (m_fwd_v) chk("m_fwd_len", 64'(fwd_len), 64'(m_fwd_len));
      chk("m_drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (m_cpu_known) chk("m_cpu_rd_data", cpu_rd_data, m_cpu_rd);
      if (m_fwd_known) chk("m_fwd_rd_data", fwd_rd_data, m_fwd_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic sel_valid(input int w);
    case (w)
      0:       return snooper_valid;
      1:       return cpu_valid;
      default: return fwd_valid;
    endcase
  endfunction

  task automatic wait_valid(input int w, input string name);
    int   n;
    logic v;
    n = 0;
    v = sel_valid(w);
    while (v !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      v = sel_valid(w);
    end
    chk(name, {63'd0, v}, 64'd1);
  endtask

  task automatic send_pkt(input logic [63:0] d, input int addr, input int len);
    wait_valid(0, "wait_snooper_valid");
    snooper_wr_en = 1'b1; snooper_wr_addr = AW'(addr); snooper_wr_data = d;
    @(negedge clk);
    snooper_wr_en = 1'b0;
    snooper_len = LW'(len); snooper_done = 1'b1;
    @(negedge clk);
    snooper_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_snooper_valid", {63'd0, snooper_valid}, 64'd0);
    chk("rst_snooper_buf", 64'(snooper_buf), 64'd0);
    chk("rst_cpu_valid", {63'd0, cpu_valid}, 64'd0);
    chk("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    chk("rst_cpu_len", 64'(cpu_len), 64'd0);
    chk("rst_fwd_len", 64'(fwd_len), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_cpu_rd_data", cpu_rd_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_grant_valid", {63'd0, snooper_valid}, 64'd1);
    chk("first_grant_buf", 64'(snooper_buf), 64'd0);
    chk("first_cpu_valid", {63'd0, cpu_valid}, 64'd0);
    cpu_rd_en = 1'b1; cpu_rd_addr = 10'd5;
    @(negedge clk);
    cpu_rd_en = 1'b0;
    chk("rd_no_owner_zero", cpu_rd_data, 64'd0);

    // single packet through CPU to forwarder
    send_pkt(64'hDEADBEEF_01234567, 5, 60);
    chk("cpu_not_yet", {63'd0, cpu_valid}, 64'd0);
    @(negedge clk);
    chk("cpu_grant_valid", {63'd0, cpu_valid}, 64'd1);
    chk("cpu_grant_len", 64'(cpu_len), 64'd60);
    chk("snooper_next_buf", 64'(snooper_buf), 64'd1);
    cpu_rd_en = 1'b1; cpu_rd_addr = 10'd5;
    @(negedge clk);
    cpu_rd_en = 1'b0;
    chk("cpu_rd_word", cpu_rd_data, 64'hDEADBEEF_01234567);
    cpu_acc = 1'b1;
    @(negedge clk);
    cpu_acc = 1'b0;
    chk("cpu_released", {63'd0, cpu_valid}, 64'd0);
    @(negedge clk);
    chk("fwd_grant_valid", {63'd0, fwd_valid}, 64'd1);
    chk("fwd_grant_len", 64'(fwd_len), 64'd60);
    chk("cpu_rd_held", cpu_rd_data, 64'hDEADBEEF_01234567);
    fwd_rd_en = 1'b1; fwd_rd_addr = 10'd4;
    @(negedge clk);
    fwd_rd_en = 1'b0;
    chk("fwd_rd_word", fwd_rd_data, 64'hDEADBEEF_01234567);

    // reset while all three agents hold buffers, with stale pulses
    send_pkt(64'h11112222_33334444, 8, 100);
    wait_valid(1, "wait_cpu_valid_b");
    wait_valid(0, "wait_snooper_valid_b");
    snooper_wr_en = 1'b1; snooper_wr_addr = 10'd2; snooper_wr_data = 64'h0F0F;
    @(negedge clk);
    snooper_wr_en = 1'b0;
    cpu_acc = 1'b1; fwd_done = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_snooper_valid", {63'd0, snooper_valid}, 64'd0);
    chk("midrst_cpu_valid", {63'd0, cpu_valid}, 64'd0);
    chk("midrst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0; cpu_acc = 1'b0; fwd_done = 1'b0;
    @(negedge clk);
    chk("postrst_snooper_valid", {63'd0, snooper_valid}, 64'd1);
    chk("postrst_snooper_buf", 64'(snooper_buf), 64'd0);
    chk("postrst_cpu_valid", {63'd0, cpu_valid}, 64'd0);
    chk("postrst_fwd_valid", {63'd0, fwd_valid}, 64'd0);

    // fill all buffers, then drop one packet
    for (int i = 0; i < NB; i++) begin
      d = 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h1_0000_0001;
      send_pkt(d, 2 * i, 10 * (i + 1));
    end
    repeat (2) @(negedge clk);
    chk("full_snooper_idle", {63'd0, snooper_valid}, 64'd0);
    snooper_wr_en = 1'b1; snooper_wr_addr = 10'd6; snooper_wr_data = 64'hBAD0_BAD0;
    @(negedge clk);
    snooper_wr_en = 1'b0;
    snooper_len = 13'd5; snooper_done = 1'b1;
    @(negedge clk);
    snooper_done = 1'b0;
    chk("drop_cnt_one", 64'(drop_cnt), 64'd1);
    for (int i = 0; i < NB; i++) begin
      d = 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h1_0000_0001;
      wait_valid(1, "wait_cpu_valid_fill");
      chk("fill_cpu_len", 64'(cpu_len), 64'(10 * (i + 1)));
      cpu_rd_en = 1'b1; cpu_rd_addr = AW'(2 * i);
      @(negedge clk);
      cpu_rd_en = 1'b0;
      chk("fill_cpu_data", cpu_rd_data, d);
      cpu_rej = 1'b1;
      @(negedge clk);
      cpu_rej = 1'b0;
    end

    // simultaneous snooper_done, fwd_done and cpu_rej
    send_pkt(64'h0000_0000_0000_00E1, 3, 11);
    wait_valid(1, "wait_cpu_valid_e1");
    cpu_acc = 1'b1;
    @(negedge clk);
    cpu_acc = 1'b0;
    wait_valid(2, "wait_fwd_valid_e1");
    send_pkt(64'h0000_0000_0000_00E2, 7, 22);
    wait_valid(1, "wait_cpu_valid_e2");
    chk("e2_cpu_len", 64'(cpu_len), 64'd22);
    wait_valid(0, "wait_snooper_valid_e3");
    snooper_wr_en = 1'b1; snooper_wr_addr = 10'd9; snooper_wr_data = 64'hCAFE_F00D_0000_00E3;
    @(negedge clk);
    snooper_wr_en = 1'b0;
    snooper_len = 13'd33; snooper_done = 1'b1; fwd_done = 1'b1; cpu_rej = 1'b1;
    @(negedge clk);
    snooper_done = 1'b0; fwd_done = 1'b0; cpu_rej = 1'b0;
    chk("sim_fwd_released", {63'd0, fwd_valid}, 64'd0);
    chk("sim_cpu_released", {63'd0, cpu_valid}, 64'd0);
    @(negedge clk);
    chk("sim_snooper_lowest", 64'(snooper_buf), 64'd0);
    chk("sim_cpu_len", 64'(cpu_len), 64'd33);

    // acc and rej together: accept wins
    cpu_acc = 1'b1; cpu_rej = 1'b1;
    @(negedge clk);
    cpu_acc = 1'b0; cpu_rej = 1'b0;
    @(negedge clk);
    chk("accrej_fwd_valid", {63'd0, fwd_valid}, 64'd1);
    chk("accrej_fwd_len", 64'(fwd_len), 64'd33);
    fwd_rd_en = 1'b1; fwd_rd_addr = 10'd9;
    @(negedge clk);
    fwd_rd_en = 1'b0;
    chk("accrej_fwd_data", fwd_rd_data, 64'hCAFE_F00D_0000_00E3);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/packetmem_nbuf.md
Name: packetmem_nbuf

Overview:
- Parametrised successor of the three-buffer packet memory: N_BUFS packet buffers shared among snooper (writer), CPU (filter reader) and forwarder (reader).
- Per-buffer ownership tracking replaces the fixed three-way rotation; buffers are handed out through explicit valid/done handshakes.
- Each buffer carries a recorded packet byte length; packets arriving with no free buffer are counted as drops.
- Sits between snooper, filter CPU (external read_size_adapter stays outside) and forwarder.

Parameters:
- ADDR_WIDTH, 10, word address width of each buffer (narrow-port words).
- DATA_WIDTH, 32, narrow word width; snooper and reader ports are 2*DATA_WIDTH wide.
- N_BUFS, 4, number of buffers; legal range 2..16.
- LEN_WIDTH, ADDR_WIDTH+3, byte-length field width.
- BUF_IDX_W, $clog2(N_BUFS), buffer index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- snooper_valid  out  1  snooper holds a buffer
- snooper_buf  out  BUF_IDX_W  index of held buffer
- snooper_wr_addr  in  ADDR_WIDTH  write address
- snooper_wr_data  in  2*DATA_WIDTH  write data
- snooper_wr_en  in  1  write strobe
- snooper_len  in  LEN_WIDTH  packet byte length, sampled with done
- snooper_done  in  1  1-cycle pulse: packet complete
- cpu_valid  out  1  CPU holds a buffer
- cpu_len  out  LEN_WIDTH  length of held packet
- cpu_rd_addr  in  ADDR_WIDTH  read address
- cpu_rd_en  in  1  read strobe
- cpu_rd_data  out  2*DATA_WIDTH  read data
- cpu_acc  in  1  1-cycle pulse: pass buffer to forwarder
- cpu_rej  in  1  1-cycle pulse: free buffer
- fwd_valid  out  1  forwarder holds a buffer
- fwd_len  out  LEN_WIDTH  length of held packet
- fwd_rd_addr  in  ADDR_WIDTH  read address
- fwd_rd_en  in  1  read strobe
- fwd_rd_data  out  2*DATA_WIDTH  read data
- fwd_done  in  1  1-cycle pulse: buffer sent
- drop_cnt  out  16  saturating dropped-packet count

Behaviour:
- Buffer states: FREE, SNOOP, Q_CPU, CPU, Q_FWD, FWD. Every buffer is in exactly one state.
- Reset: all buffers FREE; queues empty; all valid outputs 0; len outputs 0; indices 0; rd_data 0; drop_cnt 0.
- Free selection: lowest-index FREE buffer. Q_CPU and Q_FWD are FIFOs of depth N_BUFS, so order is strictly preserved.
- Grant: when an agent has no buffer and its source (free set, Q_CPU, Q_FWD) is non-empty, the buffer is assigned on the next edge and valid rises that edge. First grant after reset: snooper_valid=1, snooper_buf=0 one edge after rst falls.
- Release on done, acc or rej with valid=1:
  - Buffer leaves the agent on that edge and valid drops.
  - Re-grant happens no earlier than the following edge, so valid is low for at least 1 cycle.
  - snooper_done: SNOOP to Q_CPU; len[buf] is latched from snooper_len.
  - cpu_acc: CPU to Q_FWD. cpu_rej: CPU to FREE. If acc and rej are both high, acc wins.
  - fwd_done: FWD to FREE.
- Simultaneous events: cpu_rej and fwd_done in the same cycle both free their buffers. A buffer freed on edge k is grantable on edge k+1. Pushes and pops on the same queue in one cycle are both honoured.
- Pulses while the matching valid=0 are ignored, except snooper_done with snooper_valid=0, which increments drop_cnt (saturates at 0xFFFF).
- snooper_wr_en while snooper_valid=0 is discarded.
- Reads have 1-cycle latency. The buffer index is registered with rd_en, so data corresponds to the buffer held at the rd_en cycle even if released meanwhile.
- rd_data is held until the next rd_en. rd_en with valid=0 yields 0.
- Writes go to the full-width word at snooper_wr_addr[ADDR_WIDTH-1:1] packing, matching packet_ram's wide-port convention.
- Reset mid-operation: all ownership is lost, buffers return to FREE, and memory contents are undefined but not cleared.

Decomposition:
- Shared package: buffer-state encoding constants and a BUF_IDX_W helper function.
- Sub-module buf_idx_fifo: depth N_BUFS, width BUF_IDX_W, with push/pop/empty; instantiate twice (Q_CPU, Q_FWD).
- Memories are N_BUFS existing packet_ram instances generated in a loop, with one-hot write/read enables derived from the owner index.

Test Plan:
- Reset release, N_BUFS=4 -> one edge later snooper_valid=1, snooper_buf=0; cpu_valid=fwd_valid=0, drop_cnt=0.
- Snooper writes 0xDEADBEEF_01234567 at addr 5, len 60, then done -> cpu_valid=1 two edges later, cpu_len=60; CPU reads addr 5 and gets the word after 1 cycle; snooper_buf=1 is granted.
- Four packets with no CPU/fwd activity -> buffers 0..3 are filled; the 5th snooper_done with snooper_valid=0 gives drop_cnt=1; CPU then receives buffers 0,1,2,3 in order.
- cpu_acc on buf0, then fwd_done and cpu_rej on buf1 in the same cycle -> both freed; snooper is granted the lowest free index.
- cpu_acc and cpu_rej high together -> buffer goes to forwarder (fwd_valid=1, fwd_len preserved), not to free.
- Assert rst mid-fill with CPU and forwarder holding buffers -> all valid=0 immediately; after release snooper_buf=0; stale cpu_acc pulses during reset have no effect.
